alu_br_imm: RTL and testbench

ALU_BR_IMM -- requirements
Module: alu_br_imm

---
 rtl/alu_br_imm.sv | 148 ++++++++++++++
 tb/tb_alu_br_imm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_br_imm.sv
// alu_br_imm: immediate generator, 32-bit ALU with signed-overflow flag and
// branch-condition evaluator. All three are combinational; the ALU result,
// overflow and branch decision are also captured into a result register
// that honours en (load) and flush (clear, wins over en).
module alu_br_imm (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [2:0]  imm_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  br_type,
  output logic [31:0] imm,
  output logic [31:0] alu_out,
  output logic        overflow,
  output logic        taken,
  output logic [31:0] alu_q,
  output logic        of_q,
  output logic        taken_q
);

  localparam logic [2:0] IMM_X   = 3'd0;
  localparam logic [2:0] IMM_I   = 3'd1;
  localparam logic [2:0] IMM_U   = 3'd2;
  localparam logic [2:0] IMM_LUI = 3'd3;
  localparam logic [2:0] IMM_B   = 3'd4;
  localparam logic [2:0] IMM_J   = 3'd5;
  localparam logic [2:0] IMM_S   = 3'd6;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;
  localparam logic [3:0] OP_CPA  = 4'd13;
  localparam logic [3:0] OP_CPB  = 4'd14;

  localparam logic [2:0] BR_EQ  = 3'd1;
  localparam logic [2:0] BR_NE  = 3'd2;
  localparam logic [2:0] BR_GEZ = 3'd3;
  localparam logic [2:0] BR_GTZ = 3'd4;
  localparam logic [2:0] BR_LEZ = 3'd5;
  localparam logic [2:0] BR_LTZ = 3'd6;

  logic [31:0] pc_plus4;
  logic [31:0] sext16;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic        add_of;
  logic        sub_of;
  logic        rs1_zero;

  assign pc_plus4 = pc + 32'd4;
  assign sext16   = {{16{inst[15]}}, inst[15:0]};
  assign sum      = a + b;
  assign diff     = a - b;
  assign shamt    = b[4:0];
  // Signed overflow: add of like signs flipping, sub of unlike signs
  // producing a result whose sign differs from a.
  assign add_of   = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_of   = (a[31] != b[31]) && (diff[31] != a[31]);
  assign rs1_zero = (rs1 == 32'd0);

  // Immediate select; unused encodings drive zero.
  always_comb begin
    imm = 32'd0;
    case (imm_type)
      IMM_I:   imm = sext16;
      IMM_U:   imm = {16'd0, inst[15:0]};
      IMM_LUI: imm = {inst[15:0], 16'd0};
      IMM_B:   imm = {sext16[29:0], 2'b00};
      IMM_J:   imm = {pc_plus4[31:28], inst[25:0], 2'b00};
      IMM_S:   imm = {27'd0, inst[10:6]};
      default: imm = 32'd0;
    endcase
  end

  // ALU datapath; only ADD and SUB can report overflow.
  always_comb begin
    alu_out  = 32'd0;
    overflow = 1'b0;
    case (alu_op)
      OP_ADD:  begin alu_out = sum;  overflow = add_of; end
      OP_ADDU: alu_out = sum;
      OP_SUB:  begin alu_out = diff; overflow = sub_of; end
      OP_SUBU: alu_out = diff;
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_XOR:  alu_out = a ^ b;
      OP_NOR:  alu_out = ~(a | b);
      OP_SLT:  alu_out = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU: alu_out = {31'd0, (a < b)};
      OP_SLL:  alu_out = a << shamt;
      OP_SRL:  alu_out = a >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(a) >>> shamt);
      OP_CPA:  alu_out = a;
      OP_CPB:  alu_out = b;
      default: alu_out = 32'd0;
    endcase
  end

  // Branch condition; the zero-compare forms look only at rs1.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_EQ:   taken = (rs1 == rs2);
      BR_NE:   taken = (rs1 != rs2);
      BR_GEZ:  taken = ~rs1[31];
      BR_GTZ:  taken = ~rs1[31] & ~rs1_zero;
      BR_LEZ:  taken = rs1[31] | rs1_zero;
      BR_LTZ:  taken = rs1[31];
      default: taken = 1'b0;
    endcase
  end

  // Result register: flush clears, en loads, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= 32'd0;
      of_q    <= 1'b0;
      taken_q <= 1'b0;
    end else if (flush) begin
      alu_q   <= 32'd0;
      of_q    <= 1'b0;
      taken_q <= 1'b0;
    end else if (en) begin
      alu_q   <= alu_out;
      of_q    <= overflow;
      taken_q <= taken;
    end
  end

endmodule

// File: tb/tb_alu_br_imm.sv
// Directed bench for alu_br_imm: hand-computed vectors for the immediate
// generator, ALU and branch unit, then result-register enable/flush/reset.
module tb_alu_br_imm;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [31:0] inst, pc, a, b, rs1, rs2;
  logic [2:0]  imm_type, br_type;
  logic [3:0]  alu_op;
  logic [31:0] imm, alu_out, alu_q;
  logic        overflow, taken, of_q, taken_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_br_imm dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .inst(inst), .pc(pc), .imm_type(imm_type),
    .a(a), .b(b), .alu_op(alu_op),
    .rs1(rs1), .rs2(rs2), .br_type(br_type),
    .imm(imm), .alu_out(alu_out), .overflow(overflow), .taken(taken),
    .alu_q(alu_q), .of_q(of_q), .taken_q(taken_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp, input logic exp_of);
    alu_op = op; a = va; b = vb;
    #1;
    chk($sformatf("alu op%0d", op), alu_out, exp);
    chk($sformatf("ovf op%0d", op), {31'd0, overflow}, {31'd0, exp_of});
  endtask

  task automatic imm_vec(input logic [2:0] t, input logic [31:0] vi, input logic [31:0] vpc,
                         input logic [31:0] exp);
    imm_type = t; inst = vi; pc = vpc;
    #1;
    chk($sformatf("imm t%0d", t), imm, exp);
  endtask

  task automatic br_vec(input logic [2:0] t, input logic [31:0] r1, input logic [31:0] r2,
                        input logic exp);
    br_type = t; rs1 = r1; rs2 = r2;
    #1;
    chk($sformatf("br t%0d rs1=%h", t, r1), {31'd0, taken}, {31'd0, exp});
  endtask

  task automatic regs(input string tag, input logic [31:0] eq, input logic eo, input logic et);
    chk({tag, " alu_q"}, alu_q, eq);
    chk({tag, " of_q"}, {31'd0, of_q}, {31'd0, eo});
    chk({tag, " taken_q"}, {31'd0, taken_q}, {31'd0, et});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    inst = '0; pc = '0; a = '0; b = '0; rs1 = '0; rs2 = '0;
    imm_type = '0; br_type = '0; alu_op = '0;

    // Reset state, with combinational paths live during reset
    @(posedge clk); #1;
    regs("reset", 32'd0, 1'b0, 1'b0);
    alu_vec(4'd0, 32'd3, 32'd4, 32'd7, 1'b0);
    @(posedge clk); #1;
    regs("reset en=1", 32'd0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; en = 1'b0;

    // ALU
    alu_vec(4'd0,  32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
    alu_vec(4'd1,  32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0);
    alu_vec(4'd0,  32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b0);
    alu_vec(4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    alu_vec(4'd2,  32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1);
    alu_vec(4'd3,  32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0);
    alu_vec(4'd2,  32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
    alu_vec(4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    alu_vec(4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
    alu_vec(4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
    alu_vec(4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0);
    alu_vec(4'd8,  32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    alu_vec(4'd9,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    alu_vec(4'd10, 32'd1, 32'h21, 32'd2, 1'b0);
    alu_vec(4'd11, 32'h80000000, 32'd4, 32'h08000000, 1'b0);
    alu_vec(4'd12, 32'h80000000, 32'h24, 32'hF8000000, 1'b0);
    alu_vec(4'd12, 32'h40000000, 32'd4, 32'h04000000, 1'b0);
    alu_vec(4'd13, 32'h12345678, 32'd9, 32'h12345678, 1'b0);
    alu_vec(4'd14, 32'h12345678, 32'd9, 32'd9, 1'b0);
    alu_vec(4'd15, 32'h12345678, 32'd9, 32'd0, 1'b0);

    // Immediates
    imm_vec(3'd0, 32'hFFFFFFFF, 32'd0, 32'd0);
    imm_vec(3'd1, 32'h00008001, 32'd0, 32'hFFFF8001);
    imm_vec(3'd2, 32'h00008001, 32'd0, 32'h00008001);
    imm_vec(3'd3, 32'h00001234, 32'd0, 32'h12340000);
    imm_vec(3'd4, 32'h1000FFFF, 32'd0, 32'hFFFFFFFC);
    imm_vec(3'd5, 32'h00100000, 32'hBFC00000, 32'hB0400000);
    imm_vec(3'd5, 32'h03FFFFFF, 32'hFFFFFFFC, 32'h0FFFFFFC);
    imm_vec(3'd6, 32'hFFFFFFFF, 32'd0, 32'h0000001F);
    imm_vec(3'd6, 32'h00000040, 32'd0, 32'h00000001);
    imm_vec(3'd7, 32'hFFFFFFFF, 32'd0, 32'd0);

    // Branches
    br_vec(3'd0, 32'd5, 32'd5, 1'b0);
    br_vec(3'd1, 32'd5, 32'd5, 1'b1);
    br_vec(3'd1, 32'd5, 32'd6, 1'b0);
    br_vec(3'd2, 32'd5, 32'd5, 1'b0);
    br_vec(3'd2, 32'd5, 32'd6, 1'b1);
    br_vec(3'd3, 32'd0, 32'hFFFFFFFF, 1'b1);
    br_vec(3'd3, 32'h80000000, 32'd0, 1'b0);
    br_vec(3'd4, 32'd0, 32'd9, 1'b0);
    br_vec(3'd4, 32'd1, 32'd0, 1'b1);
    br_vec(3'd5, 32'd0, 32'd1, 1'b1);
    br_vec(3'd5, 32'h7FFFFFFF, 32'd0, 1'b0);
    br_vec(3'd6, 32'h80000000, 32'd0, 1'b1);
    br_vec(3'd6, 32'd0, 32'd0, 1'b0);
    br_vec(3'd7, 32'd5, 32'd5, 1'b0);

    // en=0 so far: registers must still be clear
    @(posedge clk); #1;
    regs("idle", 32'd0, 1'b0, 1'b0);

    // Load: ADD overflow case plus a taken EQ branch
    @(negedge clk);
    en = 1'b1; alu_op = 4'd0; a = 32'h7FFFFFFF; b = 32'd1;
    br_type = 3'd1; rs1 = 32'd3; rs2 = 32'd3;
    @(posedge clk); #1;
    regs("load1", 32'h80000000, 1'b1, 1'b1);

    // Load 5 with no overflow, no branch
    @(negedge clk);
    a = 32'd2; b = 32'd3; br_type = 3'd0;
    @(posedge clk); #1;
    regs("load2", 32'd5, 1'b0, 1'b0);

    // Hold for 3 cycles with changing inputs
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'h7FFFFFFF; b = 32'd1 + i; br_type = 3'd1; rs1 = i; rs2 = i;
      @(posedge clk); #1;
      regs($sformatf("hold%0d", i), 32'd5, 1'b0, 1'b0);
    end

    // flush and en on the same edge: clear wins
    @(negedge clk);
    en = 1'b1; flush = 1'b1; a = 32'h7FFFFFFF; b = 32'd1;
    @(posedge clk); #1;
    regs("flush", 32'd0, 1'b0, 1'b0);

    // Reload 5, then pulse rst between edges
    @(negedge clk);
    flush = 1'b0; a = 32'd2; b = 32'd3; br_type = 3'd0;
    @(posedge clk); #1;
    regs("reload", 32'd5, 1'b0, 1'b0);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    regs("async rst", 32'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    regs("post rst en=0", 32'd0, 1'b0, 1'b0);

    // Normal loading resumes after reset
    @(negedge clk); en = 1'b1; alu_op = 4'd14; b = 32'hA5A5A5A5;
    @(posedge clk); #1;
    regs("post rst load", 32'hA5A5A5A5, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
